axi_slave_mem: RTL and testbench
================================

# axi_slave_mem

AXI3-style memory-mapped responder (slave) that terminates the write and read channels carried by `axi_interface` and backs them with a word-addressed on-chip memory. It sits opposite the bus master on the same interface signal set, accepts one write burst and one read burst at a time (write and read paths independent), and returns responses with the master's transaction ID. It is the standard target for master-side verification and for simple register/scratch storage.

## Interface
- `DEPTH`, 1024, memory size in 32-bit words; power of two, ≥ 16.
- `aclk` in 1: clock; all logic on rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `awid` in 8, `awaddr` in 32, `awlen` in 4, `awsize` in 4, `awburst` in 2, `awlock` in 2, `awcache` in 4, `awprot` in 4, `awvalid` in 1: write address channel.
- `awready` out 1.
- `wid` in 8, `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1: write data channel.
- `wready` out 1.
- `bid` out 8, `bresp` out 2, `bvalid` out 1; `bready` in 1: write response channel.
- `arid` in 8, `araddr` in 32, `arlen` in 4, `arsize` in 4, `arburst` in 2, `arlock` in 2, `arcache` in 4, `arprot` in 4, `arvalid` in 1: read address channel.
- `arready` out 1.
- `rid` out 8, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1; `rready` in 1: read data channel.

## Operation
- Reset: every output 0; FSMs to IDLE; memory contents not cleared (undefined until written).
- Write FSM: W_IDLE (awready=1) → AW handshake captures id/addr/len/size/burst, clears error flag → W_DATA (wready=1, awready=0) → beat count reaches awlen on a W handshake → W_RESP (bvalid=1) → bvalid&bready → W_IDLE.
- Read FSM: R_IDLE (arready=1) → AR handshake captures fields → R_DATA (rvalid=1) → R handshake on beat arlen → R_IDLE.
- Beat count from `awlen`/`arlen` is authoritative: burst length = len+1 (1–16).
- Address: word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored (aligned down).
- Burst types: 00 FIXED (same word every beat), 01 INCR (+4 per beat), 10 WRAP (boundary = (len+1)*4; address wraps to aligned boundary base), 11 reserved.
- Errors (response codes, worst-of across a burst; DECERR beats SLVERR):
  - size ≠ 2, burst = 11, or WRAP with len ∉ {1,3,7,15} → SLVERR (10) for the whole burst, no memory writes.
  - Beat address ≥ DEPTH*4 → DECERR (11); that beat not written; read beat returns rdata 0.
  - `wid` ≠ captured `awid` on a beat → SLVERR, beat not written.
  - `wlast` value ≠ (beat == len) on any beat → SLVERR; beats still written.
- Writes: byte lane i written iff wstrb[i]; wstrb = 0 writes nothing, OKAY.
- Lock: exclusive (01) not supported → treated as normal, OKAY returned; locked (10) treated normal. cache/prot ignored.
- `bid` = captured awid; `rid` = captured arid; `rresp` per beat (invalid-burst SLVERR applies to all beats, rdata 0).
- Read/write collision on the same word in the same cycle: read returns pre-write data.

## Timing
- awready/arready rise on first rising edge after aresetn deasserts.
- AW handshake cycle N → wready=1 at N+1; W beats accepted one per cycle while wvalid.
- Last W handshake cycle M → bvalid=1 at M+1; bid/bresp stable while bvalid&!bready.
- B handshake cycle K → awready=1 at K+1 (one transaction per ≥ len+3 cycles).
- AR handshake cycle N → rvalid=1 with beat 0 at N+1; rdata/rresp/rlast/rid held stable while rvalid&!rready; next beat presented the cycle after each handshake (full throughput with rready=1).
- Last R handshake cycle K → arready=1 at K+1.
- Reset mid-burst: outputs to 0 asynchronously; partial writes already committed remain; no response for the aborted burst.

## Test plan
- INCR write awid=0x5A, addr 0x10, len=3, wdata 0x11111111..0x44444444, wstrb F → bid=0x5A, bresp 00; INCR read arid=0x3C same addr → four beats in order, rlast only on 4th, rid 0x3C, rresp 00.
- Word 0x20 = 0xFFFFFFFF, then write 0x12345678 wstrb 0101 → read back 0xFF34FF78.
- WRAP write len=3 addr 0x18 → beats land at 0x18,0x1C,0x10,0x14 (verify by INCR read at 0x10); WRAP len=2 → SLVERR, memory unchanged.
- Read araddr=DEPTH*4, len=1 → two beats rdata 0, rresp 11, rlast on beat 2; awsize=1 write → bresp 10, nothing written.
- Backpressure: bready low 5 cycles → bvalid/bid/bresp held, awready 0 throughout; rready toggling 1010 → each beat held until taken, no beat lost/duplicated.
- Assert aresetn=0 mid-read (beat 2 of 8) → all outputs 0 immediately; after release, new 1-beat read completes normally with OKAY.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI3-style memory responder: one write burst and one read burst in flight,
// FIXED/INCR/WRAP addressing over a word-addressed on-chip memory.
module axi_slave_mem #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [3:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [3:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [7:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [7:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [7:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [3:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [3:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [7:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_t;

  function automatic logic bad_burst(input logic [3:0] size, input logic [1:0] burst,
                                     input logic [3:0] len);
    return (size != 4'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
  endfunction

  // WRAP: low bits below the (len+1)*4 boundary increment, upper bits stay fixed
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [3:0] len);
    logic [31:0] mask;
    mask = {26'd0, len, 2'b11};
    case (burst)
      2'b01:   return a + 32'd4;
      2'b10:   return (a & ~mask) | ((a + 32'd4) & mask);
      default: return a;
    endcase
  endfunction

  function automatic logic out_of_range(input logic [31:0] a);
    return a[31:AW+2] != '0;
  endfunction

  logic [31:0] mem [DEPTH];

  w_state_t    w_state, w_next;
  logic [7:0]  w_id;
  logic [31:0] w_addr;
  logic [3:0]  w_len, w_beat;
  logic [1:0]  w_burst, w_resp, w_beat_resp;
  logic        w_inv, aw_hs, w_hs, w_we, w_err_id, w_oob;

  r_state_t    r_state, r_next;
  logic [7:0]  r_id;
  logic [31:0] r_addr, rd_addr, rd_word, rdata_q;
  logic [3:0]  r_len, r_beat;
  logic [1:0]  r_burst, rresp_q, rd_resp;
  logic        r_inv, rd_inv, rlast_q, ar_hs, r_hs;

  logic        unused_ok;
  assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot,
                       awaddr[1:0], araddr[1:0]};

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // ---------------- write path ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_INIT;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_INIT: w_next = W_IDLE;
      W_IDLE: if (awvalid) w_next = W_DATA;
      W_DATA: if (wvalid && (w_beat == w_len)) w_next = W_RESP;
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_INIT;
    endcase
  end

  always_comb begin
    w_oob       = out_of_range(w_addr);
    w_err_id    = (wid != w_id);
    w_beat_resp = 2'b00;
    if (w_inv) begin
      w_beat_resp = 2'b10;
    end else begin
      if (w_err_id || (wlast != (w_beat == w_len))) w_beat_resp = 2'b10;
      if (w_oob) w_beat_resp = 2'b11;
    end
    w_we = w_hs && !w_inv && !w_err_id && !w_oob;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_inv   <= 1'b0;
      w_beat  <= '0;
      w_resp  <= '0;
    end else if (aw_hs) begin
      w_id    <= awid;
      w_addr  <= {awaddr[31:2], 2'b00};
      w_len   <= awlen;
      w_burst <= awburst;
      w_inv   <= bad_burst(awsize, awburst, awlen);
      w_beat  <= '0;
      w_resp  <= '0;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_burst, w_len);
      w_beat <= w_beat + 4'd1;
      if (w_beat_resp > w_resp) w_resp <= w_beat_resp;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < 4; i++)
        if (wstrb[i]) mem[w_addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // ---------------- read path ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_INIT;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_INIT: r_next = R_IDLE;
      R_IDLE: if (arvalid) r_next = R_DATA;
      R_DATA: if (rready && rlast_q) r_next = R_IDLE;
      default: r_next = R_INIT;
    endcase
  end

  // Fetch the beat to present next: beat 0 from the AR fields, later beats from
  // the advanced address. Registered reads give pre-write data on a collision.
  always_comb begin
    if (r_state == R_DATA) begin
      rd_addr = next_addr(r_addr, r_burst, r_len);
      rd_inv  = r_inv;
    end else begin
      rd_addr = {araddr[31:2], 2'b00};
      rd_inv  = bad_burst(arsize, arburst, arlen);
    end
    rd_word = '0;
    rd_resp = 2'b00;
    if (rd_inv)                     rd_resp = 2'b10;
    else if (out_of_range(rd_addr)) rd_resp = 2'b11;
    else                            rd_word = mem[rd_addr[AW+1:2]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_inv   <= 1'b0;
      r_beat  <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
    end else if (ar_hs) begin
      r_id    <= arid;
      r_addr  <= rd_addr;
      r_len   <= arlen;
      r_burst <= arburst;
      r_inv   <= rd_inv;
      r_beat  <= '0;
      rdata_q <= rd_word;
      rresp_q <= rd_resp;
      rlast_q <= (arlen == 4'd0);
    end else if (r_hs && !rlast_q) begin
      r_addr  <= rd_addr;
      r_beat  <= r_beat + 4'd1;
      rdata_q <= rd_word;
      rresp_q <= rd_resp;
      rlast_q <= ((r_beat + 4'd1) == r_len);
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bid     = w_id;
    bresp   = w_resp;
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rid     = r_id;
    rdata   = rdata_q;
    rresp   = rresp_q;
    rlast   = rlast_q;
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized bench for axi_slave_mem against a word-array memory model with
// per-beat address lists; one negedge compare process checks every R/B beat.
module tb_axi_slave_mem;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  awid = '0, wid = '0, arid = '0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  awlen = '0, awsize = '0, awcache = '0, awprot = '0, wstrb = '0;
  logic [3:0]  arlen = '0, arsize = '0, arcache = '0, arprot = '0;
  logic [1:0]  awburst = '0, awlock = '0, arburst = '0, arlock = '0;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [57:0] outs;

  assign outs = {awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid};

  axi_slave_mem #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic [31:0] mm [DEPTH];
  rbeat_t      exp_r[$];
  logic [9:0]  exp_b[$];
  logic [31:0] got_r[$];
  logic [1:0]  got_rresp[$];
  logic [1:0]  last_bresp = '0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [1:0] burst,
                                            input int len, input int i);
    logic [31:0] a0, bound, base;
    a0 = addr & ~32'h3;
    case (burst)
      2'b01: return a0 + 32'(4 * i);
      2'b10: begin
        bound = 32'((len + 1) * 4);
        base  = (a0 / bound) * bound;
        return base + ((a0 - base + 32'(4 * i)) % bound);
      end
      default: return a0;
    endcase
  endfunction

  function automatic bit bad_burst(input logic [3:0] size, input logic [1:0] burst, input int len);
    return (size != 4'd2) || (burst == 2'b11) || (burst == 2'b10 && !(len inside {1, 3, 7, 15}));
  endfunction

  // Compare process: every R/B handshake against the model, plus hold rules under backpressure.
  rbeat_t      ce;
  logic [9:0]  eb;
  logic        prev_r_wait = 1'b0, prev_b_wait = 1'b0;
  logic [42:0] held_r;
  logic [9:0]  held_b;

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_r_wait = 1'b0;
      prev_b_wait = 1'b0;
    end else begin
      if (prev_r_wait) check("r_hold", {rvalid, rid, rdata, rresp, rlast}, {1'b1, held_r});
      if (prev_b_wait) begin
        check("b_hold", {bvalid, bid, bresp}, {1'b1, held_b});
        check("awready_during_b", awready, 0);
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) check("r_unexpected_beat", 1, 0);
        else begin
          ce = exp_r.pop_front();
          check("rid", rid, ce.id);
          check("rdata", rdata, ce.data);
          check("rresp", rresp, ce.resp);
          check("rlast", rlast, ce.last);
          got_r.push_back(rdata);
          got_rresp.push_back(rresp);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 1, 0);
        else begin
          eb = exp_b.pop_front();
          check("bid", bid, eb[9:2]);
          check("bresp", bresp, eb[1:0]);
          last_bresp = bresp;
        end
      end
      prev_r_wait = rvalid && !rready;
      held_r      = {rid, rdata, rresp, rlast};
      prev_b_wait = bvalid && !bready;
      held_b      = {bid, bresp};
    end
  end

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input logic [3:0] size, input logic [1:0] burst,
                             input int wid_bad, input int wlast_bad, input int bdelay, input bit gaps);
    logic [1:0]  resp, r;
    logic [31:0] a;
    bit          ok;
    resp = 2'b00;
    if (bad_burst(size, burst, len)) resp = 2'b10;
    else begin
      for (int i = 0; i <= len; i++) begin
        a = beat_addr(addr, burst, len, i);
        r = 2'b00;
        if (a >= LIMIT) r = 2'b11;
        else if (i == wid_bad) r = 2'b10;
        else begin
          for (int b = 0; b < 4; b++)
            if (ws[i][b]) mm[a >> 2][8*b +: 8] = wd[i][8*b +: 8];
        end
        if (i == wlast_bad && r < 2'b10) r = 2'b10;
        if (r > resp) resp = r;
      end
    end
    exp_b.push_back({id, resp});

    awid = id; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst;
    awlock = 2'($urandom_range(0, 2)); awcache = 4'($urandom); awprot = 4'($urandom);
    awvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin @(negedge aclk); ok = awready; end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    check("aw_handshake", ok, 1);
    check("wready_after_aw", wready, 1);
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wid    = (i == wid_bad) ? (id ^ 8'h81) : id;
      wlast  = ((i == len) != (i == wlast_bad));
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin @(negedge aclk); ok = wready; end
      @(posedge aclk); #1;
      check("w_handshake", ok, 1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_after_last_w", bvalid, 1);
    repeat (bdelay) begin @(posedge aclk); #1; end
    bready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin @(negedge aclk); ok = bvalid; end
    @(posedge aclk); #1;
    bready = 1'b0;
    check("b_handshake", ok, 1);
    check("awready_after_b", awready, 1);
  endtask

  task automatic push_read_model(input logic [7:0] id, input logic [31:0] addr, input int len,
                                 input logic [3:0] size, input logic [1:0] burst);
    rbeat_t      e;
    logic [31:0] a;
    for (int i = 0; i <= len; i++) begin
      e.id   = id;
      e.last = (i == len);
      if (bad_burst(size, burst, len)) begin e.data = '0; e.resp = 2'b10; end
      else begin
        a = beat_addr(addr, burst, len, i);
        if (a >= LIMIT) begin e.data = '0; e.resp = 2'b11; end
        else begin e.data = mm[a >> 2]; e.resp = 2'b00; end
      end
      exp_r.push_back(e);
    end
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input logic [3:0] size, input logic [1:0] burst);
    bit ok;
    got_r.delete();
    got_rresp.delete();
    arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst;
    arlock = 2'($urandom_range(0, 2)); arcache = 4'($urandom); arprot = 4'($urandom);
    arvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin @(negedge aclk); ok = arready; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("ar_handshake", ok, 1);
    check("rvalid_after_ar", rvalid, 1);
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input logic [3:0] size, input logic [1:0] burst, input int mode);
    int c;
    push_read_model(id, addr, len, size, burst);
    send_ar(id, addr, len, size, burst);
    c = 0;
    while (exp_r.size() > 0 && c < 200) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = ((c % 2) == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(posedge aclk); #1;
      c++;
    end
    rready = 1'b0;
    check("r_beats_drained", exp_r.size(), 0);
    check("arready_after_last_r", arready, 1);
  endtask

  task automatic check_got(input string name, input int idx, input logic [31:0] exp);
    if (got_r.size() > idx) check(name, got_r[idx], exp);
    else check({name, "_missing"}, got_r.size(), idx + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  size;
    logic [1:0]  burst;
    int          len;
    logic [31:0] wrap_lit [4];

    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs", outs, 0);
    #3 aresetn = 1'b1;
    check("awready_before_first_edge", awready, 0);
    @(posedge aclk); #1;
    check("awready_after_reset", awready, 1);
    check("arready_after_reset", arready, 1);

    // Fill the whole memory so every later read has a defined model value.
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      write_burst(8'h01, 32'(k * 64), 15, 4'd2, 2'b01, -1, -1, 0, 1'b0);
    end

    // INCR write then INCR read
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11111111 * (i + 1); ws[i] = 4'hF; end
    write_burst(8'h5A, 32'h10, 3, 4'd2, 2'b01, -1, -1, 0, 1'b0);
    check("incr_bresp_lit", last_bresp, 2'b00);
    read_burst(8'h3C, 32'h10, 3, 4'd2, 2'b01, 0);
    check_got("incr_beat0_lit", 0, 32'h11111111);
    check_got("incr_beat1_lit", 1, 32'h22222222);
    check_got("incr_beat2_lit", 2, 32'h33333333);
    check_got("incr_beat3_lit", 3, 32'h44444444);

    // Byte strobes
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    write_burst(8'h02, 32'h20, 0, 4'd2, 2'b01, -1, -1, 0, 1'b0);
    wd[0] = 32'h12345678; ws[0] = 4'b0101;
    write_burst(8'h03, 32'h20, 0, 4'd2, 2'b01, -1, -1, 0, 1'b0);
    read_burst(8'h04, 32'h20, 0, 4'd2, 2'b01, 0);
    check_got("strobe_merge_lit", 0, 32'hFF34FF78);

    // WRAP write lands at 0x18,0x1C,0x10,0x14
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0A0A0A0 + 32'(i); ws[i] = 4'hF; end
    write_burst(8'h05, 32'h18, 3, 4'd2, 2'b10, -1, -1, 0, 1'b0);
    wrap_lit[0] = 32'hA0A0A0A2; wrap_lit[1] = 32'hA0A0A0A3;
    wrap_lit[2] = 32'hA0A0A0A0; wrap_lit[3] = 32'hA0A0A0A1;
    read_burst(8'h06, 32'h10, 3, 4'd2, 2'b01, 0);
    for (int i = 0; i < 4; i++) check_got("wrap_order_lit", i, wrap_lit[i]);
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hDEAD0000 + 32'(i); ws[i] = 4'hF; end
    write_burst(8'h07, 32'h18, 2, 4'd2, 2'b10, -1, -1, 0, 1'b0);
    check("wrap_len2_bresp_lit", last_bresp, 2'b10);
    read_burst(8'h08, 32'h10, 3, 4'd2, 2'b01, 0);
    for (int i = 0; i < 4; i++) check_got("wrap_len2_unchanged_lit", i, wrap_lit[i]);

    // Out-of-range read, bad-size write
    read_burst(8'h77, LIMIT, 1, 4'd2, 2'b01, 0);
    check_got("oob_beat0_lit", 0, 32'h0);
    check_got("oob_beat1_lit", 1, 32'h0);
    if (got_rresp.size() == 2) check("oob_rresp_lit", got_rresp[1], 2'b11);
    else check("oob_rresp_count", got_rresp.size(), 2);
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    write_burst(8'h09, 32'h40, 0, 4'd1, 2'b01, -1, -1, 0, 1'b0);
    check("bad_size_bresp_lit", last_bresp, 2'b10);
    read_burst(8'h0A, 32'h40, 0, 4'd2, 2'b01, 0);

    // Backpressure on B and R
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(8'h22, 32'h80, 1, 4'd2, 2'b01, -1, -1, 5, 1'b0);
    check("bp_bresp_lit", last_bresp, 2'b00);
    read_burst(8'h33, 32'h80, 3, 4'd2, 2'b01, 1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      id    = 8'($urandom);
      addr  = $urandom_range(0, LIMIT + 63);
      len   = $urandom_range(0, 15);
      size  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
      burst = 2'($urandom_range(0, 3));
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        write_burst(id, addr, len, size, burst,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1,
                    $urandom_range(0, 3), 1'b1);
      end else begin
        read_burst(id, addr, len, size, burst, $urandom_range(0, 2));
      end
    end

    // Reset in the middle of an 8-beat read
    push_read_model(8'h55, 32'h0, 7, 4'd2, 2'b01);
    send_ar(8'h55, 32'h0, 7, 4'd2, 2'b01);
    rready = 1'b1;
    for (int t = 0; t < 20 && exp_r.size() > 6; t++) begin @(posedge aclk); #1; end
    check("beats_before_reset", exp_r.size(), 6);
    #2 aresetn = 1'b0;
    rready = 1'b0;
    #1;
    check("outputs_zero_in_reset", outs, 0);
    exp_r.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    check("arready_low_before_edge", arready, 0);
    @(posedge aclk); #1;
    check("arready_after_rerelease", arready, 1);
    read_burst(8'h44, 32'h8, 0, 4'd2, 2'b01, 0);
    if (got_rresp.size() == 1) check("post_reset_rresp_lit", got_rresp[0], 2'b00);
    else check("post_reset_beat_count", got_rresp.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
